// File: rtl/seq_div_pkg.sv
// Shared definitions for the iterative divider that sits beside the ALU.
// Contents:
//   div_state_e       divider FSM encoding (DIV_IDLE / DIV_RUN / DIV_FIX, 2 bits)
//   ALU_DIV, ALU_MOD  ALU op codes that issue onto the divider
//   ALU_SIGNED        bit of the op code that selects two's-complement operands
package seq_div_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIX  = 2'd2
  } div_state_e;

  localparam logic [3:0] ALU_DIV    = 4'hC;
  localparam logic [3:0] ALU_MOD    = 4'hD;
  localparam int         ALU_SIGNED = 3;

endpackage

// File: rtl/div_step.sv
// One restoring-division step (combinational).
// The partial remainder is shifted left by one bit, taking in the next
// dividend bit. The divisor is then trial-subtracted. When the subtraction
// does not borrow, the difference is kept and the quotient bit is 1.
// Otherwise the shifted value is restored and the quotient bit is 0.
// Ports:
//   rem_in   in  n  partial remainder (always < divisor)
//   bit_in   in  1  next dividend bit, MSB first
//   divisor  in  n  divisor magnitude (non-zero)
//   rem_out  out n  new partial remainder
//   q_bit    out 1  quotient bit produced by this step
module div_step #(
  parameter int n = 8
) (
  input  logic [n-1:0] rem_in,
  input  logic         bit_in,
  input  logic [n-1:0] divisor,
  output logic [n-1:0] rem_out,
  output logic         q_bit
);

  logic [n:0] trial_s;
  logic [n:0] diff_s;

  assign trial_s = {rem_in, bit_in};
  // Since rem_in < divisor, a non-negative difference always fits in n bits.
  // A negative one always sets bit n, so bit n serves as the borrow.
  assign diff_s  = trial_s - {1'b0, divisor};
  assign q_bit   = ~diff_s[n];
  assign rem_out = diff_s[n] ? trial_s[n-1:0] : diff_s[n-1:0];

endmodule

// File: rtl/seq_div.sv
// Iterative restoring divider (quotient and remainder) for the execute stage.
// The core stalls while busy is high.
// Configuration macro: SEQ_DIV_SIGNED_EN
//   defined   - sgn is honoured: operands are converted to magnitudes, and the
//               results are sign-corrected. The -2^(n-1) / -1 overflow is flagged.
//   undefined - every operation is unsigned and overflow stays 0.
//               The latency is the same.
// Ports:
//   clk       in   1  clock, all updates on posedge
//   rst       in   1  synchronous active-high reset (wins over start)
//   start     in   1  request, sampled only while busy==0
//   sgn       in   1  two's-complement operands
//   a, b      in   n  dividend, divisor
//   busy      out  1  operation in progress
//   done      out  1  one-cycle pulse, results valid
//   quot      out  n  quotient (held)
//   rem       out  n  remainder (held)
//   div_zero  out  1  divisor was zero (held)
//   overflow  out  1  signed overflow (held)
// Timing:
//   An accepted start at edge k raises done during the cycle that ends at
//   edge k+n+1. For b==0, done is raised during the cycle that ends at edge k+1.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sgn,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] quot,
  output logic [n-1:0] rem,
  output logic         div_zero,
  output logic         overflow
);

  localparam int            CW       = $clog2(n);
  localparam logic [CW-1:0] CNT_LAST = CW'(n - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  div_state_e   state_r, state_s;
  logic [n-1:0] shf_r, shf_s;     // dividend bits shifting out / quotient bits shifting in
  logic [n-1:0] dvs_r, dvs_s;     // divisor magnitude
  logic [n-1:0] part_r, part_s;   // partial remainder
  logic [CW-1:0] cnt_r, cnt_s;
  logic         neg_q_r, neg_q_s;
  logic         neg_r_r, neg_r_s;
  logic         ovf_r, ovf_s;

  logic         busy_s, done_s, div_zero_s, overflow_s;
  logic [n-1:0] quot_s, rem_s;

  logic [n-1:0] step_rem_s;
  logic         step_q_s;
  logic [n-1:0] q_fin_s;

  // Operand pre-processing for the accepted request
  logic [n-1:0] a_mag_s, b_mag_s;
  logic         neg_q_in_s, neg_r_in_s, ovf_in_s;

`ifdef SEQ_DIV_SIGNED_EN
  // Two's-complement magnitude. The most negative value maps to 2^(n-1) as unsigned.
  function automatic logic [n-1:0] abs_val(input logic [n-1:0] v, input logic neg);
    return neg ? (~v + {{(n-1){1'b0}}, 1'b1}) : v;
  endfunction

  assign a_mag_s    = abs_val(a, sgn & a[n-1]);
  assign b_mag_s    = abs_val(b, sgn & b[n-1]);
  assign neg_q_in_s = sgn & (a[n-1] ^ b[n-1]);
  assign neg_r_in_s = sgn & a[n-1];
  // For -2^(n-1) / -1 the magnitude quotient 2^(n-1) already has the required bit pattern.
  // Only the flag is needed.
  assign ovf_in_s   = sgn & (a == {1'b1, {(n-1){1'b0}}}) & (b == {n{1'b1}});
`else
  logic unused_sgn_s;
  assign unused_sgn_s = sgn;
  assign a_mag_s    = a;
  assign b_mag_s    = b;
  assign neg_q_in_s = 1'b0;
  assign neg_r_in_s = 1'b0;
  assign ovf_in_s   = 1'b0;
`endif

  div_step #(.n(n)) u_step (
    .rem_in  (part_r),
    .bit_in  (shf_r[n-1]),
    .divisor (dvs_r),
    .rem_out (step_rem_s),
    .q_bit   (step_q_s)
  );

  assign q_fin_s = {shf_r[n-2:0], step_q_s};

  // Next-state and next-output logic
  always_comb begin
    state_s    = state_r;
    shf_s      = shf_r;
    dvs_s      = dvs_r;
    part_s     = part_r;
    cnt_s      = cnt_r;
    neg_q_s    = neg_q_r;
    neg_r_s    = neg_r_r;
    ovf_s      = ovf_r;
    busy_s     = busy;
    done_s     = 1'b0;
    quot_s     = quot;
    rem_s      = rem;
    div_zero_s = div_zero;
    overflow_s = overflow;

    case (state_r)
      DIV_IDLE: begin
        if (start) begin
          busy_s     = 1'b1;
          div_zero_s = 1'b0;
          overflow_s = 1'b0;
          if (b == {n{1'b0}}) begin
            // Divide by zero skips the iterations.
            // Results are loaded now, so they are valid while FIX raises done.
            state_s    = DIV_FIX;
            done_s     = 1'b1;
            quot_s     = {n{1'b1}};
            rem_s      = a;
            div_zero_s = 1'b1;
          end else begin
            state_s = DIV_RUN;
            shf_s   = a_mag_s;
            dvs_s   = b_mag_s;
            part_s  = {n{1'b0}};
            cnt_s   = CNT_LAST;
            neg_q_s = neg_q_in_s;
            neg_r_s = neg_r_in_s;
            ovf_s   = ovf_in_s;
          end
        end else begin
          state_s = DIV_IDLE;
        end
      end

      DIV_RUN: begin
        shf_s  = q_fin_s;
        part_s = step_rem_s;
        if (cnt_r == CNT_ZERO) begin
          // The last step's outputs are sign-corrected on the way into FIX.
          // The corrected results are therefore valid during the done cycle.
          state_s    = DIV_FIX;
          done_s     = 1'b1;
          quot_s     = neg_q_r ? (~q_fin_s + {{(n-1){1'b0}}, 1'b1}) : q_fin_s;
          rem_s      = neg_r_r ? (~step_rem_s + {{(n-1){1'b0}}, 1'b1}) : step_rem_s;
          overflow_s = ovf_r;
        end else begin
          cnt_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
        end
      end

      DIV_FIX: begin
        state_s = DIV_IDLE;
        busy_s  = 1'b0;
      end

      default: begin
        state_s = DIV_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= DIV_IDLE;
      shf_r    <= {n{1'b0}};
      dvs_r    <= {n{1'b0}};
      part_r   <= {n{1'b0}};
      cnt_r    <= CNT_ZERO;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      ovf_r    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      quot     <= {n{1'b0}};
      rem      <= {n{1'b0}};
      div_zero <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state_r  <= state_s;
      shf_r    <= shf_s;
      dvs_r    <= dvs_s;
      part_r   <= part_s;
      cnt_r    <= cnt_s;
      neg_q_r  <= neg_q_s;
      neg_r_r  <= neg_r_s;
      ovf_r    <= ovf_s;
      busy     <= busy_s;
      done     <= done_s;
      quot     <= quot_s;
      rem      <= rem_s;
      div_zero <= div_zero_s;
      overflow <= overflow_s;
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div (n=8).
// Each accepted request pushes its expected results, together with the cycle
// in which done must appear, onto a queue. The monitor pops the entry and
// compares it when done is seen. It also verifies that the outputs hold for
// one cycle after each done.
module tb_seq_div;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst, start, sgn;
  logic [N-1:0] a, b;
  logic         busy, done, div_zero, overflow;
  logic [N-1:0] quot, rem;

  seq_div #(.n(N)) dut (
    .clk(clk), .rst(rst), .start(start), .sgn(sgn), .a(a), .b(b),
    .busy(busy), .done(done), .quot(quot), .rem(rem),
    .div_zero(div_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
    logic         ov;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   vec_cnt = 0;
  int   err_cnt = 0;
  bit   mon_en = 1'b0;
  bit   hold_pend = 1'b0;
  exp_t last;

`ifdef SEQ_DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model for a single division.
  function automatic exp_t model(input logic [N-1:0] av, input logic [N-1:0] bv, input logic sv);
    exp_t e;
    int   sa, sb_i;
    e.dz = 1'b0;
    e.ov = 1'b0;
    e.due = 0;
    if (bv == 8'd0) begin
      e.q  = 8'hFF;
      e.r  = av;
      e.dz = 1'b1;
    end else if (SIGNED_EN && sv) begin
      if (av == 8'h80 && bv == 8'hFF) begin
        e.q  = 8'h80;
        e.r  = 8'h00;
        e.ov = 1'b1;
      end else begin
        sa   = $signed(av);
        sb_i = $signed(bv);
        e.q  = 8'(sa / sb_i);
        e.r  = 8'(sa % sb_i);
      end
    end else begin
      e.q = av / bv;
      e.r = av % bv;
    end
    return e;
  endfunction

  // Issue one request once the divider is free.
  // k is the index of the rising edge that accepts the request.
  task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv, input logic sv,
                        output int k);
    exp_t e;
    int   guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check_eq("busy_timeout", 32'(busy), 32'd0);
    a = av; b = bv; sgn = sv; start = 1'b1;
    k = cyc + 1;
    e = model(av, bv, sv);
    // done is high in the cycle that ends at edge k+lat.
    // That cycle is sampled at the falling edge while cyc == k+lat-1.
    e.due = k + ((bv == 8'd0) ? 1 : N + 1) - 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    if (bv != 8'd0) check_eq("flags_clr", {30'd0, div_zero, overflow}, 32'd0);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((sb.size() != 0 || busy) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check_eq("done_timeout", 32'(sb.size()), 32'd0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (hold_pend) begin
        hold_pend = 1'b0;
        check_eq("hold_quot", 32'(quot), 32'(last.q));
        check_eq("hold_rem", 32'(rem), 32'(last.r));
        check_eq("hold_flags", {30'd0, div_zero, overflow}, {30'd0, last.dz, last.ov});
        check_eq("done_pulse", 32'(done), 32'd0);
      end else if (done) begin
        if (sb.size() == 0) begin
          check_eq("spurious_done", 32'(done), 32'd0);
        end else begin
          last = sb.pop_front();
          check_eq("done_cycle", 32'(cyc), 32'(last.due));
          check_eq("quot", 32'(quot), 32'(last.q));
          check_eq("rem", 32'(rem), 32'(last.r));
          check_eq("div_zero", 32'(div_zero), 32'(last.dz));
          check_eq("overflow", 32'(overflow), 32'(last.ov));
          check_eq("busy_at_done", 32'(busy), 32'd1);
          hold_pend = 1'b1;
        end
      end
    end
  end

  initial begin
    int k;
    logic [N-1:0] ra, rb;
    rst = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_quot", 32'(quot), 32'd0);
    check_eq("rst_rem", 32'(rem), 32'd0);
    check_eq("rst_flags", {30'd0, div_zero, overflow}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    run_op(8'd200, 8'd7, 1'b0, k);
    run_op(8'd5, 8'd0, 1'b0, k);
    run_op(8'd5, 8'd3, 1'b0, k);        // clears div_zero
    run_op(8'hF9, 8'd2, 1'b1, k);       // -7 / 2
    run_op(8'h80, 8'hFF, 1'b1, k);      // -128 / -1
    run_op(8'd7, 8'hFE, 1'b1, k);       // 7 / -2
    run_op(8'h80, 8'd0, 1'b1, k);       // signed divide by zero
    run_op(8'd255, 8'd255, 1'b0, k);
    run_op(8'd0, 8'd1, 1'b1, k);
    wait_idle();

    // A start while busy must be ignored.
    run_op(8'd100, 8'd10, 1'b0, k);
    while (cyc < k + 3) @(negedge clk);
    a = 8'd9; b = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Reset mid-operation aborts the operation without a done pulse.
    run_op(8'd255, 8'd16, 1'b0, k);
    while (cyc < k + 4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    sb.delete();
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_quot", 32'(quot), 32'd0);
    check_eq("abort_rem", 32'(rem), 32'd0);
    rst = 1'b0;
    run_op(8'd255, 8'd16, 1'b0, k);
    wait_idle();

    for (int i = 0; i < 12; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      run_op(ra, rb, 1'($urandom_range(0, 1)), k);
    end
    wait_idle();
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
